regbank_wb_arbiter: RTL

//  Shares the single write port of the 32x32 register bank between NUM_REQ writeback sources
//  (e.g. ALU result, load data, link/JAL). Round-robin arbitration, valid/ready per requester,

---
 rtl/regbank_wb_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/regbank_wb_arbiter.sv
// Round-robin arbiter sharing the register-bank write port among NUM_REQ writeback sources.
// Optional build macro WBARB_ZERO_FILTER_EN: accepted writes to address 0 are consumed without writing.
module regbank_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  RegWrite,
  output logic [AW-1:0]         WA,
  output logic [DW-1:0]         WD,
  input  logic                  flush,
  output logic [CNT_W-1:0]      conf_cnt
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

  logic [AW-1:0]      addr_arr [NUM_REQ];
  logic [DW-1:0]      data_arr [NUM_REQ];

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               regwrite_q, regwrite_d;
  logic [AW-1:0]      wa_q, wa_d;
  logic [DW-1:0]      wd_q, wd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PTR_W-1:0]   idx, win;
  logic               found, accept, multi, seen, keep_wr;
  logic [NUM_REQ-1:0] gnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*AW +: AW];
    assign data_arr[g] = req_data[g*DW +: DW];
  end

  // (base + off) mod NUM_REQ; both operands are already below NUM_REQ
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W:0]   off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + off;
    if (s >= NREQ) s = s - NREQ;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    gnt   = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    multi = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap_inc(rr_ptr_q, (PTR_W+1)'(k));
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      if (req_valid[k]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    accept = found && rst_n && !flush;
    if (accept) gnt[win] = 1'b1;
  end

  assign req_ready = gnt;

`ifdef WBARB_ZERO_FILTER_EN
  assign keep_wr = (addr_arr[win] != '0);
`else
  assign keep_wr = 1'b1;
`endif

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    regwrite_d = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    cnt_d      = cnt_q;
    if (multi && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    if (flush) begin
      rr_ptr_d = '0;
    end else if (accept) begin
      rr_ptr_d = wrap_inc(win, (PTR_W+1)'(1));
      if (keep_wr) begin
        regwrite_d = 1'b1;
        wa_d       = addr_arr[win];
        wd_d       = data_arr[win];
      end
    end
  end

  // Registered write command toward the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign WA       = wa_q;
  assign WD       = wd_q;
  assign conf_cnt = cnt_q;

endmodule
